// File: rtl/bn_res_sched_layer7_pkg.sv
// Shared types and encodings for the layer-7 BN+residual sequencer.
// Mode values mirror the datapath's RELOAD/CALCULATE encodings.
package layer7_pkg;

  localparam int CHANNEL_NUM_DEF = 512;
  localparam int LOAD_LANES_DEF  = 16;
  localparam int PIXEL_NUM_DEF   = 16;

  localparam int CH_AW = $clog2(CHANNEL_NUM_DEF);
  localparam int PIX_W = $clog2(PIXEL_NUM_DEF);

  localparam logic MODE_RELOAD    = 1'b0;
  localparam logic MODE_CALCULATE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_CALC   = 3'd3,
    ST_DRAIN  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/bn_res_sched_layer7_loader.sv
// Parameter-load address generator: beat base address, bank strobes, last-beat flag.
module bn_para_loader #(
  parameter int CHANNEL_NUM = 512,
  parameter int LOAD_LANES  = 16,
  localparam int AW         = $clog2(CHANNEL_NUM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load_en,
  input  logic          bank_b,
  input  logic          para_valid,
  output logic [AW-1:0] para_addr,
  output logic          para_we_a,
  output logic          para_we_b,
  output logic          beat,
  output logic          last_beat
);

  logic [AW-1:0] addr_reg;

  assign beat      = load_en & para_valid;
  assign para_we_a = beat & ~bank_b;
  assign para_we_b = beat & bank_b;
  assign last_beat = (addr_reg == AW'(CHANNEL_NUM - LOAD_LANES));
  assign para_addr = addr_reg;

  // The address wraps to 0 on the last beat so bank B starts at word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= '0;
    end else if (clear) begin
      addr_reg <= '0;
    end else if (beat) begin
      addr_reg <= last_beat ? '0 : addr_reg + AW'(LOAD_LANES);
    end
  end

endmodule

// File: rtl/bn_res_sched_layer7.sv
// Layer-7 BN+residual sequencer: parameter reload, pixel pairing, drain and done.
// Optional stall counter enabled by defining BN_RES_SCHED_PERF_EN.
module bn_res_sched_layer7
  import layer7_pkg::*;
#(
  parameter int CHANNEL_NUM = CHANNEL_NUM_DEF,
  parameter int LOAD_LANES  = LOAD_LANES_DEF,
  parameter int PIXEL_NUM   = PIXEL_NUM_DEF,
  localparam int AW         = $clog2(CHANNEL_NUM),
  localparam int PW         = $clog2(PIXEL_NUM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_load,
  input  logic          start_calc,
  input  logic          abort,
  input  logic          para_valid,
  output logic          para_ready,
  output logic          para_we_a,
  output logic          para_we_b,
  output logic [AW-1:0] para_addr,
  input  logic          mac_valid,
  output logic          mac_ready,
  input  logic          res_valid,
  output logic          res_ready,
  output logic          mode,
  output logic          data_e,
  input  logic          data_e_out,
  output logic          params_ok,
  output logic          busy,
  output logic          done,
  output logic [15:0]   stall_cnt
);

  generate
    if (CHANNEL_NUM % LOAD_LANES != 0) begin : g_bad_lanes
      $error("CHANNEL_NUM must be a multiple of LOAD_LANES");
    end
  endgenerate

  sched_state_t  state_reg;
  logic          mode_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          params_ok_reg;
  logic [PW-1:0] pix_cnt_reg;

  logic in_load;
  logic fire;
  logic calc_accept;
  logic beat;
  logic last_beat;
  logic loader_clear;

  assign in_load      = (state_reg == ST_LOAD_A) || (state_reg == ST_LOAD_B);
  assign fire         = (state_reg == ST_CALC) & mac_valid & res_valid;
  assign calc_accept  = (state_reg == ST_IDLE) & ~abort & ~start_load & start_calc & params_ok_reg;
  assign loader_clear = abort | ((state_reg == ST_IDLE) & start_load);

  assign para_ready = in_load;
  assign data_e     = fire;
  assign mac_ready  = fire;
  assign res_ready  = fire;
  assign mode       = mode_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign params_ok  = params_ok_reg;

  bn_para_loader #(
    .CHANNEL_NUM (CHANNEL_NUM),
    .LOAD_LANES  (LOAD_LANES)
  ) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (loader_clear),
    .load_en    (in_load),
    .bank_b     (state_reg == ST_LOAD_B),
    .para_valid (para_valid),
    .para_addr  (para_addr),
    .para_we_a  (para_we_a),
    .para_we_b  (para_we_b),
    .beat       (beat),
    .last_beat  (last_beat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      mode_reg      <= MODE_RELOAD;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      params_ok_reg <= 1'b0;
      pix_cnt_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      if (abort) begin
        // A partial parameter set is unusable, so only an aborted load drops params_ok.
        if (in_load) params_ok_reg <= 1'b0;
        state_reg   <= ST_IDLE;
        mode_reg    <= MODE_RELOAD;
        busy_reg    <= 1'b0;
        pix_cnt_reg <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start_load) begin
              state_reg     <= ST_LOAD_A;
              mode_reg      <= MODE_RELOAD;
              busy_reg      <= 1'b1;
              params_ok_reg <= 1'b0;
            end else if (calc_accept) begin
              state_reg <= ST_CALC;
              mode_reg  <= MODE_CALCULATE;
              busy_reg  <= 1'b1;
            end
          end
          ST_LOAD_A: begin
            if (beat && last_beat) state_reg <= ST_LOAD_B;
          end
          ST_LOAD_B: begin
            if (beat && last_beat) begin
              state_reg     <= ST_IDLE;
              busy_reg      <= 1'b0;
              params_ok_reg <= 1'b1;
            end
          end
          ST_CALC: begin
            if (fire) begin
              if (pix_cnt_reg == PW'(PIXEL_NUM - 1)) begin
                state_reg   <= ST_DRAIN;
                pix_cnt_reg <= '0;
              end else begin
                pix_cnt_reg <= pix_cnt_reg + 1'b1;
              end
            end
          end
          ST_DRAIN: begin
            if (data_e_out) begin
              state_reg <= ST_IDLE;
              mode_reg  <= MODE_RELOAD;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            mode_reg  <= MODE_RELOAD;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef BN_RES_SCHED_PERF_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (calc_accept) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg == ST_CALC) && !fire && (stall_cnt_reg != 16'hffff)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_bn_res_sched_layer7.sv
// Scoreboard bench for bn_res_sched_layer7: expected strobes queued by stimulus, checked by a monitor.
module tb_bn_res_sched_layer7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_load = 1'b0;
  logic        start_calc = 1'b0;
  logic        abort = 1'b0;
  logic        para_valid = 1'b0;
  logic        para_ready;
  logic        para_we_a;
  logic        para_we_b;
  logic [8:0]  para_addr;
  logic        mac_valid = 1'b0;
  logic        mac_ready;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic        mode;
  logic        data_e;
  logic        data_e_out;
  logic        params_ok;
  logic        busy;
  logic        done;
  logic [15:0] stall_cnt;

`ifdef BN_RES_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef enum {EV_WA, EV_WB, EV_DE, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       addr;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  bn_res_sched_layer7 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_load (start_load),
    .start_calc (start_calc),
    .abort      (abort),
    .para_valid (para_valid),
    .para_ready (para_ready),
    .para_we_a  (para_we_a),
    .para_we_b  (para_we_b),
    .para_addr  (para_addr),
    .mac_valid  (mac_valid),
    .mac_ready  (mac_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .mode       (mode),
    .data_e     (data_e),
    .data_e_out (data_e_out),
    .params_ok  (params_ok),
    .busy       (busy),
    .done       (done),
    .stall_cnt  (stall_cnt)
  );

  // Datapath model with a fixed one-cycle latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_e_out <= 1'b0;
    else        data_e_out <= data_e;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic push(input ev_kind_t k, input int a);
    ev_t e;
    e.kind = k;
    e.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic mon_event(input ev_kind_t k, input int a);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual=%s/%0d expected=none", k.name(), a);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr != a) begin
        failures++;
        $display("FAIL event actual=%s/%0d expected=%s/%0d", k.name(), a, e.kind.name(), e.addr);
      end else begin
        $display("ev   %s addr=%0d", k.name(), a);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (para_we_a) mon_event(EV_WA, int'(para_addr));
      if (para_we_b) mon_event(EV_WB, int'(para_addr));
      if (data_e)    mon_event(EV_DE, 0);
      if (done)      mon_event(EV_DONE, 0);
      if (mac_ready !== data_e || res_ready !== data_e) begin
        checks++;
        failures++;
        $display("FAIL ready_pairing actual=mac%0b/res%0b expected=%0b", mac_ready, res_ready, data_e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int gap_mod);
    int beats;
    int cyc;
    for (int i = 0; i < 64; i++) push((i < 32) ? EV_WA : EV_WB, (i % 32) * 16);
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    chk("load_params_cleared", params_ok, 0);
    chk("load_busy", busy, 1);
    chk("load_mode_reload", mode, 0);
    beats = 0;
    cyc   = 0;
    while (beats < 64 && cyc < 300) begin
      para_valid = (gap_mod == 0) || (cyc % gap_mod != 0);
      if (para_valid) beats++;
      cyc++;
      tick();
    end
    para_valid = 1'b0;
    chk("load_params_ok", params_ok, 1);
    chk("load_idle", busy, 0);
  endtask

  task automatic calc_start();
    start_calc = 1'b1;
    tick();
    start_calc = 1'b0;
    chk("calc_busy", busy, 1);
    chk("calc_mode", mode, 1);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mode", mode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_params_ok", params_ok, 0);
    chk("rst_para_addr", para_addr, 0);
    chk("rst_para_ready", para_ready, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_done", done, 0);
    #3 rst_n = 1'b1;
    tick();

    // start_calc without parameters is ignored
    start_calc = 1'b1;
    mac_valid  = 1'b1;
    res_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("guard_busy", busy, 0);
      chk("guard_data_e", data_e, 0);
    end
    start_calc = 1'b0;
    mac_valid  = 1'b0;
    res_valid  = 1'b0;
    tick();

    do_load(0);

    // mac held, residual toggling: 16 fires over 32 cycles, 16 stalls
    for (int i = 0; i < 16; i++) push(EV_DE, 0);
    push(EV_DONE, 0);
    calc_start();
    for (int c = 0; c < 32; c++) begin
      mac_valid = 1'b1;
      res_valid = c[0];
      tick();
    end
    mac_valid = 1'b0;
    res_valid = 1'b0;
    chk("drain_mode", mode, 1);
    repeat (3) tick();
    chk("calc1_idle", busy, 0);
    chk("calc1_mode", mode, 0);
    chk("calc1_stall", stall_cnt, PERF ? 16 : 0);

    // Residual missing: nothing consumed, then abort out of CALC
    calc_start();
    mac_valid = 1'b1;
    res_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("pair_mac_ready", mac_ready, 0);
      tick();
    end
    mac_valid = 1'b0;
    abort     = 1'b1;
    tick();
    abort = 1'b0;
    chk("calc_abort_idle", busy, 0);
    chk("calc_abort_params_kept", params_ok, 1);
    chk("calc_abort_stall", stall_cnt, PERF ? 11 : 0);
    repeat (2) tick();

    // Abort at beat 40 (bank B, word 128)
    for (int i = 0; i < 40; i++) push((i < 32) ? EV_WA : EV_WB, (i % 32) * 16);
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    para_valid = 1'b1;
    repeat (40) tick();
    para_valid = 1'b0;
    chk("abort_load_addr", para_addr, 128);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_load_idle", busy, 0);
    chk("abort_load_params", params_ok, 0);
    chk("abort_load_addr0", para_addr, 0);
    chk("abort_load_ready", para_ready, 0);
    tick();

    do_load(3);

    // Asynchronous reset after 7 fires
    for (int i = 0; i < 7; i++) push(EV_DE, 0);
    calc_start();
    mac_valid = 1'b1;
    res_valid = 1'b1;
    repeat (7) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_mode", mode, 0);
    chk("arst_data_e", data_e, 0);
    chk("arst_params_ok", params_ok, 0);
    chk("arst_stall", stall_cnt, 0);
    chk("arst_para_addr", para_addr, 0);
    mac_valid = 1'b0;
    res_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    do_load(0);
    for (int i = 0; i < 16; i++) push(EV_DE, 0);
    push(EV_DONE, 0);
    calc_start();
    mac_valid = 1'b1;
    res_valid = 1'b1;
    repeat (16) tick();
    mac_valid = 1'b0;
    res_valid = 1'b0;
    repeat (3) tick();
    chk("calc2_idle", busy, 0);
    chk("calc2_stall", stall_cnt, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
